ultrasonic_echo_responder: RTL
==============================

Name: ultrasonic_echo_responder

Overview:
- Cycle-accurate FPGA/bench emulator of the ultrasonic ranging module: the far end of the trig/echo interface that our ultrasonic driver (`sonic_top`) initiates.
- Watches `trig`, validates the pulse width, waits a fixed burst time, then drives `echo` high for a width proportional to a programmable distance.
- Drives the car's ultrasonic front end on the bench and on a second board, so stop-distance logic is testable without real hardware.

Parameters:
- CYC_PER_US, 100, clk cycles per microsecond (100 MHz clock).
- TRIG_MIN_US, 10, minimum accepted trig high width in us.
- BURST_US, 200, delay from accepted trig fall to echo rise, in us.
- US_PER_CM, 58, echo high time per cm of distance, in us.
- MAX_CM, 400, largest reportable distance in cm; above this is treated as no target.
- MIN_CM, 2, smallest reportable distance in cm; smaller values are clamped up to it.
- TIMEOUT_US, 38000, echo width reported when there is no target, in us.
- HOLDOFF_US, 1000, dead time after echo falls during which trig is ignored, in us.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- trig  in  1  trigger from the ranging driver; asynchronous to the emulator, so it passes through a 2-FF synchronizer.
- distance_cm  in  9  emulated distance in cm; sampled once per measurement.
- target_valid  in  1  1 = a target is present; 0 = no target, so echo uses TIMEOUT_US.
- echo  out  1  echo pulse, registered.
- busy  out  1  high in BURST, ECHO and HOLDOFF.
- meas_done  out  1  one-cycle pulse on the cycle echo falls.
- trig_err  out  1  one-cycle pulse when a trig pulse is rejected as too short.

Behaviour:
- Reset values: echo=0, busy=0, meas_done=0, trig_err=0, state=IDLE, all counters 0, synchronizer flops 0.
- trig_s is the synchronized trig (2-cycle latency). Only trig_s and its registered copy drive edge detection.
- Microsecond prescaler: clears on every state entry; us_tick asserts when it reaches CYC_PER_US-1, then it wraps. The us counter (16 bit) clears on state entry and increments on us_tick.
- FSM states:
  - IDLE: on trig_s rising edge, go to TRIG_HIGH. The cycle counter starts at 1 on that edge.
  - TRIG_HIGH: count clk cycles while trig_s=1; saturate at TRIG_MIN_US*CYC_PER_US. On trig_s falling edge:
    - if count >= TRIG_MIN_US*CYC_PER_US: latch the distance, go to BURST.
    - else: pulse trig_err, go to IDLE.
  - Trig held high indefinitely keeps the FSM in TRIG_HIGH.
  - Distance latch rule, in priority order:
    - target_valid=0 or distance_cm>MAX_CM: W_us = TIMEOUT_US.
    - distance_cm<MIN_CM: W_us = MIN_CM*US_PER_CM.
    - otherwise: W_us = distance_cm*US_PER_CM.
  - Compute W_us with a 16-bit product; 400*58 = 23200 fits. Distance inputs changing after the latch have no effect on the current measurement.
  - BURST: echo=0. After exactly BURST_US*CYC_PER_US cycles, set echo=1 and go to ECHO.
  - ECHO: echo=1 for exactly W_us*CYC_PER_US cycles. Then set echo=0, pulse meas_done on that same cycle, and go to HOLDOFF.
  - HOLDOFF: lasts exactly HOLDOFF_US*CYC_PER_US cycles, then IDLE. Any trig activity is ignored.
- Trig edges during BURST, ECHO or HOLDOFF are ignored. A trig that is still high on entry to IDLE does not start a measurement; a fresh rising edge is required.
- End-to-end timing, with t0 = the edge on which the trig pin is first sampled low:
  - TRIG_HIGH is left at t0+2.
  - echo rises at t0+2+BURST_US*CYC_PER_US.
  - The bench checks these exactly, with 0 cycles tolerance.
- rst mid-operation: the next edge forces all outputs and state to reset values; echo drops immediately and no meas_done pulse is issued.
- meas_done and trig_err never assert in the same cycle.

Test Plan:
- Valid trig of 12 us (1200 cycles), distance_cm=10, target_valid=1 -> echo rises 20000 cycles after trig_s falls; high for exactly 58000 cycles; meas_done pulses once; busy falls 100000 cycles later.
- Trig of 5 us (500 cycles) -> trig_err single pulse at trig_s fall; echo stays 0; busy stays 0.
- distance_cm=450 (or target_valid=0) -> echo high for exactly 3_800_000 cycles; distance_cm=0 -> 11600 cycles (2 cm clamp).
- Second trig pulse during ECHO and during HOLDOFF -> ignored; echo width unchanged. A new trig after HOLDOFF -> normal measurement.
- distance_cm changed from 10 to 100 during BURST -> echo width stays 58000 cycles; the next measurement uses 580000.
- rst asserted mid-ECHO -> echo=0 and busy=0 on the next edge; no meas_done. A subsequent valid trig measures normally.

Source files
------------

// File: rtl/ultrasonic_echo_responder.sv
`default_nettype none
// ============================================================================
// Module   : ultrasonic_echo_responder
// Brief    : Far-end emulator of an ultrasonic ranging module: validates trig,
//            waits the burst time, then returns an echo sized by distance_cm.
// Revision : 1.0
// ============================================================================
module ultrasonic_echo_responder #(
    parameter int CYC_PER_US  = 100,
    parameter int TRIG_MIN_US = 10,
    parameter int BURST_US    = 200,
    parameter int US_PER_CM   = 58,
    parameter int MAX_CM      = 400,
    parameter int MIN_CM      = 2,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    input  logic       target_valid,
    output logic       echo,
    output logic       busy,
    output logic       meas_done,
    output logic       trig_err
);

    localparam int c_TRIG_MIN_CYC = TRIG_MIN_US * CYC_PER_US;
    localparam int c_TCNT_W       = $clog2(c_TRIG_MIN_CYC + 1);
    localparam int c_PRE_W        = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;

    localparam logic [c_TCNT_W-1:0] c_TRIG_MIN  = c_TCNT_W'(c_TRIG_MIN_CYC);
    localparam logic [c_TCNT_W-1:0] c_TCNT_ONE  = c_TCNT_W'(1);
    localparam logic [c_PRE_W-1:0]  c_PRE_LAST  = c_PRE_W'(CYC_PER_US - 1);
    localparam logic [c_PRE_W-1:0]  c_PRE_ONE   = c_PRE_W'(1);
    localparam logic [15:0]         c_BURST_LAST = 16'(BURST_US - 1);
    localparam logic [15:0]         c_HOLD_LAST  = 16'(HOLDOFF_US - 1);
    localparam logic [15:0]         c_TIMEOUT    = 16'(TIMEOUT_US);
    localparam logic [15:0]         c_MIN_W      = 16'(MIN_CM * US_PER_CM);
    localparam logic [15:0]         c_US_PER_CM  = 16'(US_PER_CM);
    localparam logic [8:0]          c_MAX_CM     = 9'(MAX_CM);
    localparam logic [8:0]          c_MIN_CM     = 9'(MIN_CM);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_TRIG_HIGH = 3'd1;
    localparam logic [2:0] c_ST_BURST     = 3'd2;
    localparam logic [2:0] c_ST_ECHO      = 3'd3;
    localparam logic [2:0] c_ST_HOLDOFF   = 3'd4;

    logic                r_trig_meta;
    logic                r_trig_s;
    logic                r_trig_d;
    logic [2:0]          r_state;
    logic [c_TCNT_W-1:0] r_tcnt;
    logic [c_PRE_W-1:0]  r_pre;
    logic [15:0]         r_us;
    logic [15:0]         r_w_us;
    logic                r_echo;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_rise;
    logic                w_fall;
    logic                w_us_tick;
    logic [15:0]         w_w_us;
    logic [15:0]         w_echo_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig_meta <= 1'b0;
            r_trig_s    <= 1'b0;
            r_trig_d    <= 1'b0;
        end else begin
            r_trig_meta <= trig;
            r_trig_s    <= r_trig_meta;
            r_trig_d    <= r_trig_s;
        end
    end

    assign w_rise      = r_trig_s & ~r_trig_d;
    assign w_fall      = ~r_trig_s & r_trig_d;
    assign w_us_tick   = (r_pre == c_PRE_LAST);
    assign w_echo_last = r_w_us - 16'd1;

    // Echo width in us: no-target timeout wins over the near-range clamp.
    always_comb begin
        w_w_us = {7'd0, distance_cm} * c_US_PER_CM;
        if (!target_valid || (distance_cm > c_MAX_CM)) begin
            w_w_us = c_TIMEOUT;
        end else if (distance_cm < c_MIN_CM) begin
            w_w_us = c_MIN_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_tcnt  <= '0;
            r_pre   <= '0;
            r_us    <= '0;
            r_w_us  <= '0;
            r_echo  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_us_tick) begin
                r_pre <= '0;
                r_us  <= r_us + 16'd1;
            end else begin
                r_pre <= r_pre + c_PRE_ONE;
            end

            // Every transition below also restarts the microsecond timebase.
            case (r_state)
                c_ST_IDLE: begin
                    if (w_rise) begin
                        r_state <= c_ST_TRIG_HIGH;
                        r_tcnt  <= c_TCNT_ONE;
                        r_pre   <= '0;
                        r_us    <= '0;
                    end
                end
                c_ST_TRIG_HIGH: begin
                    if (w_fall) begin
                        if (r_tcnt >= c_TRIG_MIN) begin
                            r_w_us  <= w_w_us;
                            r_busy  <= 1'b1;
                            r_state <= c_ST_BURST;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end
                        r_pre <= '0;
                        r_us  <= '0;
                    end else if (r_trig_s && (r_tcnt != c_TRIG_MIN)) begin
                        r_tcnt <= r_tcnt + c_TCNT_ONE;
                    end
                end
                c_ST_BURST: begin
                    if (w_us_tick && (r_us == c_BURST_LAST)) begin
                        r_echo  <= 1'b1;
                        r_state <= c_ST_ECHO;
                        r_pre   <= '0;
                        r_us    <= '0;
                    end
                end
                c_ST_ECHO: begin
                    if (w_us_tick && (r_us == w_echo_last)) begin
                        r_echo  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_ST_HOLDOFF;
                        r_pre   <= '0;
                        r_us    <= '0;
                    end
                end
                c_ST_HOLDOFF: begin
                    if (w_us_tick && (r_us == c_HOLD_LAST)) begin
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                        r_pre   <= '0;
                        r_us    <= '0;
                    end
                end
                default: begin
                    r_echo  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign echo      = r_echo;
    assign busy      = r_busy;
    assign meas_done = r_done;
    assign trig_err  = r_err;

endmodule
`default_nettype wire
